// File: rtl/glay_kernel_cache_responder.sv
// ---------------------------------------------------------------------------
// glay_kernel_cache_responder
//
// Cache-side responder for the GLay setup request path. Requests from the
// kernel setup engine are queued in a FIFO and executed one at a time
// against a single-port memory. Each request yields exactly one tagged
// response, so every request completes as a request/response pair.
//
// Ports
//   ap_clk, areset         : single clock, synchronous active-high reset
//   req_in_*               : request stream in (valid/ready, we, addr, id, data)
//   mem_req_*              : memory command out (valid/ready, we, addr, wdata)
//   mem_rsp_valid/rdata    : memory read return, one-cycle pulse
//   rsp_out_*              : response stream out (valid/ready, we, id, data)
//   idle                   : FIFO empty and FSM in IDLE
//   rsp_count              : completed responses, wraps modulo 2^32
//   err_unexpected_rsp     : sticky, memory returned data outside WAIT
//
// Every output is driven directly by a flop; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module glay_kernel_cache_responder #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 512,
    parameter int ID_W       = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              ap_clk,
    input  logic              areset,

    // Request stream from the setup engine
    input  logic              req_in_valid,
    output logic              req_in_ready,
    input  logic              req_in_we,
    input  logic [ADDR_W-1:0] req_in_addr,
    input  logic [ID_W-1:0]   req_in_id,
    input  logic [DATA_W-1:0] req_in_data,

    // Memory command channel
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,

    // Memory read return
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,

    // Response stream back to the setup engine
    output logic              rsp_out_valid,
    input  logic              rsp_out_ready,
    output logic              rsp_out_we,
    output logic [ID_W-1:0]   rsp_out_id,
    output logic [DATA_W-1:0] rsp_out_data,

    // Status
    output logic              idle,
    output logic [31:0]       rsp_count,
    output logic              err_unexpected_rsp
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q,         state_d;

    logic [PTR_W-1:0]   wr_ptr_q,        wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,        rd_ptr_d;
    logic [CNT_W-1:0]   count_q,         count_d;
    logic               req_in_ready_q,  req_in_ready_d;

    logic               mem_req_valid_q, mem_req_valid_d;
    logic               mem_req_we_q,    mem_req_we_d;
    logic [ADDR_W-1:0]  mem_req_addr_q,  mem_req_addr_d;
    logic [DATA_W-1:0]  mem_req_wdata_q, mem_req_wdata_d;
    logic [ID_W-1:0]    cmd_id_q,        cmd_id_d;

    logic               rsp_valid_q,     rsp_valid_d;
    logic               rsp_we_q,        rsp_we_d;
    logic [ID_W-1:0]    rsp_id_q,        rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q,      rsp_data_d;

    logic               idle_q,          idle_d;
    logic [31:0]        rsp_count_q,     rsp_count_d;
    logic               err_q,           err_d;

    req_t               fifo_mem [FIFO_DEPTH];
    req_t               push_entry;
    req_t               head;
    logic               push;
    logic               pop;

    assign push_entry = '{we:   req_in_we,
                          addr: req_in_addr,
                          id:   req_in_id,
                          data: req_in_data};
    assign head       = fifo_mem[rd_ptr_q];

    // Ready is a flop reflecting the current occupancy, so a push can only
    // be accepted while the FIFO is strictly below full.
    assign push = req_in_valid && req_in_ready_q;

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    // NOTE: the data RAM has no reset; only pointers and count are cleared,
    // which is enough to flush it and keeps it mappable onto block RAM.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every _d gets its hold value first so that no path through the
    // case statement leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d         = state_q;
        pop             = 1'b0;

        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        cmd_id_d        = cmd_id_q;

        rsp_valid_d     = rsp_valid_q;
        rsp_we_d        = rsp_we_q;
        rsp_id_d        = rsp_id_q;
        rsp_data_d      = rsp_data_q;

        rsp_count_d     = rsp_count_q;
        err_d           = err_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    // Pop the head straight into the command register so the
                    // memory command is launched from flops next cycle.
                    pop             = 1'b1;
                    mem_req_valid_d = 1'b1;
                    mem_req_we_d    = head.we;
                    mem_req_addr_d  = head.addr;
                    mem_req_wdata_d = head.we ? head.data : '0;
                    cmd_id_d        = head.id;
                    state_d         = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (mem_req_we_q) begin
                        // Writes complete on command acceptance; no data
                        // comes back from memory.
                        rsp_valid_d = 1'b1;
                        rsp_we_d    = 1'b1;
                        rsp_id_d    = cmd_id_q;
                        rsp_data_d  = '0;
                        state_d     = S_RESP;
                    end else begin
                        state_d     = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b0;
                    rsp_id_d    = cmd_id_q;
                    rsp_data_d  = mem_rsp_rdata;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                if (rsp_out_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_count_d = rsp_count_q + 32'd1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data arriving while no read is outstanding is discarded and
        // latched as an error until the next reset.
        if (mem_rsp_valid && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end
    end

    // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth,
    // and a simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        wr_ptr_d       = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d       = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
        req_in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        idle_d         = (count_d == '0) && (state_d == S_IDLE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            req_in_ready_q  <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            cmd_id_q        <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_we_q        <= 1'b0;
            rsp_id_q        <= '0;
            rsp_data_q      <= '0;
            idle_q          <= 1'b1;
            rsp_count_q     <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            req_in_ready_q  <= req_in_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            cmd_id_q        <= cmd_id_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_we_q        <= rsp_we_d;
            rsp_id_q        <= rsp_id_d;
            rsp_data_q      <= rsp_data_d;
            idle_q          <= idle_d;
            rsp_count_q     <= rsp_count_d;
            err_q           <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign req_in_ready       = req_in_ready_q;
    assign mem_req_valid      = mem_req_valid_q;
    assign mem_req_we         = mem_req_we_q;
    assign mem_req_addr       = mem_req_addr_q;
    assign mem_req_wdata      = mem_req_wdata_q;
    assign rsp_out_valid      = rsp_valid_q;
    assign rsp_out_we         = rsp_we_q;
    assign rsp_out_id         = rsp_id_q;
    assign rsp_out_data       = rsp_data_q;
    assign idle               = idle_q;
    assign rsp_count          = rsp_count_q;
    assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_glay_kernel_cache_responder.sv
// ---------------------------------------------------------------------------
// Directed testbench for glay_kernel_cache_responder. Inputs are driven and
// outputs sampled on the falling edge, half a cycle away from the active
// rising edge. Each sampling point is one design cycle.
// ---------------------------------------------------------------------------
module tb_glay_kernel_cache_responder;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 512;
    localparam int ID_W       = 8;
    localparam int FIFO_DEPTH = 32;

    logic              ap_clk = 1'b0;
    logic              areset;
    logic              req_in_valid;
    logic              req_in_ready;
    logic              req_in_we;
    logic [ADDR_W-1:0] req_in_addr;
    logic [ID_W-1:0]   req_in_id;
    logic [DATA_W-1:0] req_in_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
    logic              rsp_out_valid;
    logic              rsp_out_ready;
    logic              rsp_out_we;
    logic [ID_W-1:0]   rsp_out_id;
    logic [DATA_W-1:0] rsp_out_data;
    logic              idle;
    logic [31:0]       rsp_count;
    logic              err_unexpected_rsp;

    int                checks   = 0;
    int                failures = 0;
    logic [31:0]       exp_count;
    logic [DATA_W-1:0] pattern_a5;

    always #5 ap_clk = ~ap_clk;

    glay_kernel_cache_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ap_clk             (ap_clk),
        .areset             (areset),
        .req_in_valid       (req_in_valid),
        .req_in_ready       (req_in_ready),
        .req_in_we          (req_in_we),
        .req_in_addr        (req_in_addr),
        .req_in_id          (req_in_id),
        .req_in_data        (req_in_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_we         (mem_req_we),
        .mem_req_addr       (mem_req_addr),
        .mem_req_wdata      (mem_req_wdata),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_rdata      (mem_rsp_rdata),
        .rsp_out_valid      (rsp_out_valid),
        .rsp_out_ready      (rsp_out_ready),
        .rsp_out_we         (rsp_out_we),
        .rsp_out_id         (rsp_out_id),
        .rsp_out_data       (rsp_out_data),
        .idle               (idle),
        .rsp_count          (rsp_count),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge ap_clk);
    endtask

    task automatic drive_req(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data);
        req_in_valid = 1'b1;
        req_in_we    = we;
        req_in_addr  = addr;
        req_in_id    = id;
        req_in_data  = data;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req_in_ready"},  req_in_ready,       0);
        check({tag, " mem_req_valid"}, mem_req_valid,      0);
        check({tag, " mem_req_we"},    mem_req_we,         0);
        check({tag, " mem_req_addr"},  mem_req_addr,       0);
        check({tag, " mem_req_wdata"}, mem_req_wdata,      0);
        check({tag, " rsp_out_valid"}, rsp_out_valid,      0);
        check({tag, " rsp_out_we"},    rsp_out_we,         0);
        check({tag, " rsp_out_id"},    rsp_out_id,         0);
        check({tag, " rsp_out_data"},  rsp_out_data,       0);
        check({tag, " idle"},          idle,               1);
        check({tag, " rsp_count"},     rsp_count,          0);
        check({tag, " err"},           err_unexpected_rsp, 0);
    endtask

    // Waits (bounded) for the next response with rsp_out_ready held high,
    // checks its fields and steps past the handshake edge.
    task automatic expect_rsp(input string tag, input logic [ID_W-1:0] id,
                              input logic we, input logic [DATA_W-1:0] data);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp_out_valid) begin
                seen = 1'b1;
                check({tag, " id"},   rsp_out_id,   id);
                check({tag, " we"},   rsp_out_we,   we);
                check({tag, " data"}, rsp_out_data, data);
                exp_count = exp_count + 32'd1;
            end
            tick();
        end
        check({tag, " arrived"}, seen, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_rsp;
        logic seen_mem;
        int   accepted;

        pattern_a5    = {64{8'hA5}};
        exp_count     = 32'd0;
        areset        = 1'b1;
        req_in_valid  = 1'b0;
        req_in_we     = 1'b0;
        req_in_addr   = '0;
        req_in_id     = '0;
        req_in_data   = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        rsp_out_ready = 1'b1;

        // ---------------- Reset values ----------------
        repeat (3) tick();
        check_reset_values("reset");
        areset = 1'b0;
        tick();
        check("post_reset req_in_ready", req_in_ready, 1);
        check("post_reset idle",         idle,         1);

        // ---------------- Single read ----------------
        drive_req(1'b0, 64'h1000, 8'h05, '0);                 // cycle T
        tick();                                               // T+1
        req_in_valid = 1'b0;
        check("rd T+1 idle",          idle,          0);
        check("rd T+1 mem_req_valid", mem_req_valid, 0);
        tick();                                               // T+2
        check("rd T+2 mem_req_valid", mem_req_valid, 1);
        check("rd T+2 mem_req_addr",  mem_req_addr,  64'h1000);
        check("rd T+2 mem_req_we",    mem_req_we,    0);
        tick();                                               // T+3
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = pattern_a5;
        check("rd T+3 mem_req_valid", mem_req_valid, 0);
        check("rd T+3 rsp_out_valid", rsp_out_valid, 0);
        tick();                                               // T+4
        mem_rsp_valid = 1'b0;
        check("rd T+4 rsp_out_valid", rsp_out_valid, 1);
        check("rd T+4 rsp_out_id",    rsp_out_id,    8'h05);
        check("rd T+4 rsp_out_data",  rsp_out_data,  pattern_a5);
        check("rd T+4 rsp_out_we",    rsp_out_we,    0);
        tick();                                               // T+5
        exp_count = 32'd1;
        check("rd rsp_count",         rsp_count,     exp_count);
        check("rd rsp_out_valid low", rsp_out_valid, 0);
        check("rd idle",              idle,          1);
        check("rd err",               err_unexpected_rsp, 0);

        // ---------------- Single write ----------------
        drive_req(1'b1, 64'h2000, 8'h07, 512'h1234);          // cycle T
        tick();                                               // T+1
        req_in_valid = 1'b0;
        tick();                                               // T+2
        check("wr T+2 mem_req_valid", mem_req_valid, 1);
        check("wr T+2 mem_req_we",    mem_req_we,    1);
        check("wr T+2 mem_req_addr",  mem_req_addr,  64'h2000);
        check("wr T+2 mem_req_wdata", mem_req_wdata, 512'h1234);
        tick();                                               // T+3
        check("wr T+3 rsp_out_valid", rsp_out_valid, 1);
        check("wr T+3 rsp_out_we",    rsp_out_we,    1);
        check("wr T+3 rsp_out_id",    rsp_out_id,    8'h07);
        check("wr T+3 rsp_out_data",  rsp_out_data,  0);
        tick();                                               // T+4
        exp_count = 32'd2;
        check("wr rsp_count",         rsp_count,     exp_count);

        // ---------------- Response backpressure ----------------
        rsp_out_ready = 1'b0;
        drive_req(1'b1, 64'h3000, 8'h10, 512'hBEEF);          // cycle T
        tick();
        drive_req(1'b1, 64'h3040, 8'h11, 512'hCAFE);          // T+1
        tick();
        req_in_valid = 1'b0;                                  // T+2
        tick();                                               // T+3: RESP
        for (int i = 0; i < 10; i++) begin
            check("bp rsp_out_valid", rsp_out_valid, 1);
            check("bp rsp_out_id",    rsp_out_id,    8'h10);
            check("bp rsp_out_we",    rsp_out_we,    1);
            check("bp rsp_out_data",  rsp_out_data,  0);
            check("bp mem_req_valid", mem_req_valid, 0);
            check("bp rsp_count",     rsp_count,     exp_count);
            tick();
        end
        rsp_out_ready = 1'b1;
        expect_rsp("bp first",  8'h10, 1'b1, '0);
        expect_rsp("bp second", 8'h11, 1'b1, '0);
        tick();
        check("bp rsp_count", rsp_count, exp_count);

        // ---------------- Full FIFO ----------------
        mem_req_ready = 1'b0;
        accepted      = 0;
        for (int i = 0; i < 34; i++) begin
            drive_req(1'b1, ADDR_W'(i * 64), ID_W'(i), DATA_W'(i + 1));
            if (req_in_ready) accepted++;
            tick();
        end
        req_in_valid = 1'b0;
        check("full accepted",      accepted,      33);
        check("full req_in_ready",  req_in_ready,  0);
        check("full mem_req_valid", mem_req_valid, 1);
        check("full mem_req_addr",  mem_req_addr,  0);
        check("full mem_req_wdata", mem_req_wdata, 1);
        repeat (3) tick();
        check("full hold mem_req_addr", mem_req_addr, 0);
        check("full hold req_in_ready", req_in_ready, 0);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 33; i++) begin
            expect_rsp("full rsp", ID_W'(i), 1'b1, '0);
        end
        seen_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_out_valid) seen_rsp = 1'b1;
            tick();
        end
        check("full no extra rsp",  seen_rsp,     0);
        check("full rsp_count",     rsp_count,    exp_count);
        check("full idle",          idle,         1);
        check("full req_in_ready",  req_in_ready, 1);

        // ---------------- Unexpected memory response ----------------
        check("unexp err before", err_unexpected_rsp, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = {DATA_W{1'b1}};
        tick();
        mem_rsp_valid = 1'b0;
        check("unexp err set",       err_unexpected_rsp, 1);
        check("unexp rsp_count",     rsp_count,          exp_count);
        check("unexp rsp_out_valid", rsp_out_valid,      0);
        repeat (4) tick();
        check("unexp err sticky",    err_unexpected_rsp, 1);
        check("unexp idle",          idle,               1);

        // ---------------- Reset during WAIT ----------------
        drive_req(1'b0, 64'h4000, 8'h20, '0);                 // cycle T
        tick();
        drive_req(1'b0, 64'h4040, 8'h21, '0);                 // T+1
        tick();
        drive_req(1'b0, 64'h4080, 8'h22, '0);                 // T+2
        tick();                                               // T+3: WAIT
        req_in_valid = 1'b0;
        check("mwr in-wait mem_req_valid", mem_req_valid, 0);
        check("mwr in-wait rsp_out_valid", rsp_out_valid, 0);
        check("mwr in-wait mem_req_addr",  mem_req_addr,  64'h4000);
        check("mwr in-wait idle",          idle,          0);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_reset_values("mwr");
        seen_rsp = 1'b0;
        seen_mem = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_out_valid) seen_rsp = 1'b1;
            if (mem_req_valid) seen_mem = 1'b1;
        end
        check("mwr no response",     seen_rsp,     0);
        check("mwr no mem command",  seen_mem,     0);
        check("mwr idle",            idle,         1);
        check("mwr rsp_count",       rsp_count,    0);
        check("mwr req_in_ready",    req_in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glay_kernel_cache_responder.md
# glay_kernel_cache_responder

Cache-side responder for the GLay setup request path. Accepts cache request packets issued by the kernel setup engine, buffers them in an internal FIFO, and executes them one at a time against a single-port memory interface. Returns one tagged response per request to the setup engine, so each request completes as a request/response pair.

## Interface

Reset is synchronous and active-high, sampled on `ap_clk`. The block uses one clock.

Parameters:
- `ADDR_W`, 64: request and memory address width.
- `DATA_W`, 512: cache line data width.
- `ID_W`, 8: request tag width, echoed in the response.
- `FIFO_DEPTH`, 32: request FIFO entries; power of two, at least 2.

Ports:
- `ap_clk`, in, 1: the single clock.
- `areset`, in, 1: synchronous, active-high reset.
- `req_in_valid`, in, 1: request present.
- `req_in_ready`, out, 1: FIFO can accept a request; equals `!fifo_full`.
- `req_in_we`, in, 1: 1 = write, 0 = read.
- `req_in_addr`, in, ADDR_W: line address.
- `req_in_id`, in, ID_W: request tag.
- `req_in_data`, in, DATA_W: write data; ignored for reads.
- `mem_req_valid`, out, 1: memory command valid.
- `mem_req_ready`, in, 1: memory accepts the command.
- `mem_req_we`, out, 1: memory command is a write.
- `mem_req_addr`, out, ADDR_W: memory command address.
- `mem_req_wdata`, out, DATA_W: memory write data.
- `mem_rsp_valid`, in, 1: read data valid; one-cycle pulse.
- `mem_rsp_rdata`, in, DATA_W: read data.
- `rsp_out_valid`, out, 1: response valid.
- `rsp_out_ready`, in, 1: consumer accepts the response.
- `rsp_out_we`, out, 1: response belongs to a write.
- `rsp_out_id`, out, ID_W: echoed tag.
- `rsp_out_data`, out, DATA_W: read data; 0 for writes.
- `idle`, out, 1: FIFO empty and FSM in IDLE.
- `rsp_count`, out, 32: completed responses; wraps modulo 2^32.
- `err_unexpected_rsp`, out, 1: sticky; set by `mem_rsp_valid` outside WAIT.

## Operation

- **Push:** a request is pushed when `req_in_valid && req_in_ready`. The FIFO occupancy counter has width clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, ISSUE, WAIT, RESP. Only one request is in flight at a time.
- **IDLE:** if the FIFO is not empty, pop the head into a command register and go to ISSUE. Otherwise stay.
- **ISSUE:** hold `mem_req_valid=1` with stable `mem_req_*` until `mem_req_ready`.
  - On handshake for a write: load response `we=1`, `data=0`, go to RESP.
  - On handshake for a read: go to WAIT.
- **WAIT:** on `mem_rsp_valid`, capture `mem_rsp_rdata` into the response register and go to RESP. There is no timeout.
- **RESP:** hold `rsp_out_valid=1` with stable fields until `rsp_out_ready`.
  - On handshake: increment `rsp_count` and go to IDLE.
  - If the FIFO is non-empty at that edge, IDLE pops on the next cycle.
- **Push and pop in the same cycle:** occupancy is unchanged, data ordering is preserved, and the pointers advance independently.
- **FIFO full:** `req_in_ready=0`. `req_in_valid` is ignored, with no push and no corruption.
- **`mem_rsp_valid` in IDLE, ISSUE or RESP:** dropped, and `err_unexpected_rsp` is set. Only reset clears it.
- **Reset mid-operation:** an in-flight request is abandoned and not re-issued. The FIFO is flushed by zeroing the pointers and count. The FSM goes to IDLE. Data RAM contents are don't-care.

## Timing

- **Reset values:**
  - `req_in_ready=0` during reset, 1 from the first cycle after reset deasserts.
  - `mem_req_valid=0`, `mem_req_we=0`, `mem_req_addr=0`, `mem_req_wdata=0`.
  - `rsp_out_valid=0`, `rsp_out_we=0`, `rsp_out_id=0`, `rsp_out_data=0`.
  - `idle=1`, `rsp_count=0`, `err_unexpected_rsp=0`.
- **All outputs are registered.** There is no combinational path from any input to any output.
- **Minimum latency**, with the request accepted at cycle T into an empty FIFO and the FSM in IDLE:
  - FIFO non-empty at T+1; IDLE pops at T+1.
  - `mem_req_valid=1` at T+2.
  - Write with `mem_req_ready=1` at T+2: `rsp_out_valid=1` at T+3.
  - Read with `mem_rsp_valid` at T+3: `rsp_out_valid=1` at T+4.
- **Back-to-back throughput** with zero-wait memory and a ready consumer: one write per 3 cycles, one read per 4 cycles.
- **`idle`** is registered and deasserts the cycle after the first push.

## Test plan

- **Single read:** reset, push read id=0x05 addr=0x1000; memory ready, `rsp_rdata`=0xA5..A5 one cycle after the handshake. Required: `mem_req_addr=0x1000` at T+2, response id=0x05, data=0xA5..A5, `we=0` at T+4, `rsp_count=1`.
- **Write:** push write id=0x07 data=0x1234. Required: `mem_req_we=1`, `wdata=0x1234`; response `we=1`, `data=0`, id=0x07 at T+3.
- **Full FIFO:** hold `mem_req_ready=0`, push 34 requests. Required: the FIFO holds 32 and `req_in_ready=0` afterwards; the FSM holds one popped request in ISSUE. After releasing, exactly 33 responses return in id order 0..32.
- **Backpressure:** `rsp_out_ready=0` for 10 cycles during RESP. Required: `rsp_out_*` stable, no new `mem_req_valid`. Completion follows once ready rises.
- **Unexpected response:** pulse `mem_rsp_valid` in IDLE. Required: `err_unexpected_rsp=1` stays set and `rsp_count` is unchanged.
- **Mid-WAIT reset:** assert `areset` one cycle during WAIT with 3 queued requests. Required: all outputs at reset values, `idle=1`, no response emitted afterwards.
